// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the loop-back test pattern generator:
// mode, config-address and state codes plus the LFSR step function.
package test_pattern_gen_pkg;

    typedef enum logic [1:0] {
        TPG_COUNT = 2'd0,
        TPG_WALK  = 2'd1,
        TPG_LFSR  = 2'd2,
        TPG_PLAY  = 2'd3
    } tpg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } tpg_state_e;

    localparam logic [1:0]  CFG_ADDR_MODE = 2'd0;
    localparam logic [1:0]  CFG_ADDR_DIV  = 2'd1;
    localparam logic [1:0]  CFG_ADDR_LEN  = 2'd2;
    localparam logic [1:0]  CFG_ADDR_SEED = 2'd3;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] WALK_SEED     = 16'h0001;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

    // Fibonacci step: taps 16,14,13,11 folded into bit 0 while shifting left
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tpg_ram.sv
// Playback pattern store: simple dual-port RAM with a registered read port.
// A same-address write and read in one cycle returns the previous contents.
module tpg_ram
    import test_pattern_gen_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              sampleClock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_r;

    // Write port and registered read port; no reset so the array maps to RAM
    always_ff @(posedge sampleClock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[rd_addr];
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/test_pattern_gen.sv
// Loop-back stimulus source: IDLE/LOAD/RUN sequencer, prescaler and four
// pattern engines (counter, walking one, LFSR16, RAM playback).
module test_pattern_gen
    import test_pattern_gen_pkg::*;
#(
    parameter int PAT_DEPTH = 6
) (
    input  logic                 sampleClock,
    input  logic                 extReset,
    input  logic                 enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_addr,
    input  logic [31:0]          cfg_data,
    input  logic                 pat_wr,
    input  logic [PAT_DEPTH-1:0] pat_addr,
    input  logic [15:0]          pat_data,
    output logic [15:0]          pattern_out,
    output logic                 pattern_oe,
    output logic                 frame_strobe
);

    tpg_state_e           state_r, state_s;
    tpg_mode_e            mode_r;
    logic [15:0]          div_r, seed_r, presc_r, pattern_r;
    logic [PAT_DEPTH-1:0] len_r, cur_addr_r;
    logic                 enable_d_r, oe_r, strobe_r, cfg_ready_r;

    logic                 cfg_fire_s, restart_s, tick_s, adv_s, wrap_s;
    logic [15:0]          eff_seed_s, next_pat_s, seed_pat_s, rd_data_s;
    logic [PAT_DEPTH-1:0] play_nxt_s, rd_addr_s;
    logic                 unused_cfg_s;

    function automatic logic [PAT_DEPTH-1:0] play_next(
        input logic [PAT_DEPTH-1:0] addr,
        input logic [PAT_DEPTH-1:0] len
    );
        if (addr == len) begin
            return {PAT_DEPTH{1'b0}};
        end else begin
            return addr + {{(PAT_DEPTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign unused_cfg_s = ^cfg_data[31:16];
    assign cfg_fire_s   = cfg_valid & cfg_ready_r;
    assign restart_s    = cfg_fire_s & ((cfg_addr == CFG_ADDR_MODE) | (cfg_addr == CFG_ADDR_SEED));

    // Sequencer next state; a dropping enable wins over a restart request
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && !enable_d_r) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else if (restart_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign eff_seed_s = (seed_r == 16'h0000) ? LFSR_ZERO_SUB : seed_r;
    assign play_nxt_s = play_next(cur_addr_r, len_r);
    assign tick_s     = (state_r == ST_RUN) && (presc_r == 16'd0);
    assign adv_s      = tick_s && (state_s == ST_RUN);

    // Per-mode successor, seed value and wrap detection
    always_comb begin
        next_pat_s = pattern_r;
        seed_pat_s = 16'h0000;
        wrap_s     = 1'b0;
        case (mode_r)
            TPG_COUNT: begin
                next_pat_s = pattern_r + 16'd1;
                seed_pat_s = 16'h0000;
                wrap_s     = (next_pat_s == 16'h0000);
            end
            TPG_WALK: begin
                next_pat_s = {pattern_r[14:0], pattern_r[15]};
                seed_pat_s = WALK_SEED;
                wrap_s     = (next_pat_s == WALK_SEED);
            end
            TPG_LFSR: begin
                next_pat_s = lfsr_next(pattern_r);
                seed_pat_s = eff_seed_s;
                wrap_s     = (next_pat_s == eff_seed_s);
            end
            TPG_PLAY: begin
                next_pat_s = rd_data_s;
                seed_pat_s = rd_data_s;
                wrap_s     = (play_nxt_s == {PAT_DEPTH{1'b0}});
            end
            default: begin
                next_pat_s = pattern_r;
                seed_pat_s = 16'h0000;
                wrap_s     = 1'b0;
            end
        endcase
    end

    // Read address runs one word ahead of the displayed word so a tick never stalls
    always_comb begin
        rd_addr_s = play_nxt_s;
        if (state_s == ST_LOAD) begin
            rd_addr_s = {PAT_DEPTH{1'b0}};
        end else if (state_r == ST_LOAD) begin
            rd_addr_s = play_next({PAT_DEPTH{1'b0}}, len_r);
        end else if (adv_s) begin
            rd_addr_s = play_next(play_nxt_s, len_r);
        end else begin
            rd_addr_s = play_nxt_s;
        end
    end

    // Sequencer, configuration, prescaler and pattern registers
    always_ff @(posedge sampleClock or posedge extReset) begin
        if (extReset) begin
            state_r     <= ST_IDLE;
            enable_d_r  <= 1'b0;
            cfg_ready_r <= 1'b1;
            oe_r        <= 1'b0;
            strobe_r    <= 1'b0;
            mode_r      <= TPG_COUNT;
            div_r       <= 16'h0000;
            len_r       <= {PAT_DEPTH{1'b1}};
            seed_r      <= 16'h0001;
            presc_r     <= 16'h0000;
            pattern_r   <= 16'h0000;
            cur_addr_r  <= {PAT_DEPTH{1'b0}};
        end else begin
            state_r     <= state_s;
            enable_d_r  <= enable;
            cfg_ready_r <= (state_s != ST_LOAD);
            oe_r        <= (state_s == ST_RUN);
            strobe_r    <= 1'b0;
            if (cfg_fire_s) begin
                case (cfg_addr)
                    CFG_ADDR_MODE: mode_r <= tpg_mode_e'(cfg_data[1:0]);
                    CFG_ADDR_DIV:  div_r  <= cfg_data[15:0];
                    CFG_ADDR_LEN:  len_r  <= cfg_data[PAT_DEPTH-1:0];
                    CFG_ADDR_SEED: seed_r <= cfg_data[15:0];
                    default:       mode_r <= mode_r;
                endcase
            end
            if (state_r == ST_LOAD) begin
                presc_r    <= div_r;
                pattern_r  <= seed_pat_s;
                cur_addr_r <= {PAT_DEPTH{1'b0}};
            end else if (adv_s) begin
                presc_r    <= div_r;
                pattern_r  <= next_pat_s;
                strobe_r   <= wrap_s;
                cur_addr_r <= play_nxt_s;
            end else if ((state_r == ST_RUN) && (presc_r != 16'd0)) begin
                presc_r    <= presc_r - 16'd1;
            end
        end
    end

    tpg_ram #(
        .ADDR_W (PAT_DEPTH),
        .DATA_W (16)
    ) u_ram (
        .sampleClock (sampleClock),
        .wr_en       (pat_wr),
        .wr_addr     (pat_addr),
        .wr_data     (pat_data),
        .rd_addr     (rd_addr_s),
        .rd_data     (rd_data_s)
    );

    assign pattern_out  = pattern_r;
    assign pattern_oe   = oe_r;
    assign frame_strobe = strobe_r;
    assign cfg_ready    = cfg_ready_r;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen: directed corner runs plus random
// configurations compared against a sequence-level reference model.
module tb_test_pattern_gen;

    logic        sampleClock = 1'b0;
    logic        extReset, enable, cfg_valid, cfg_ready, pat_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [5:0]  pat_addr;
    logic [15:0] pat_data, pattern_out;
    logic        pattern_oe, frame_strobe;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode_m, div_m, len_m;
    logic [15:0] seed_m, last_pat_m;
    logic [15:0] ram_m [0:63];

    test_pattern_gen #(.PAT_DEPTH(6)) dut (
        .sampleClock  (sampleClock),
        .extReset     (extReset),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .pat_wr       (pat_wr),
        .pat_addr     (pat_addr),
        .pat_data     (pat_data),
        .pattern_out  (pattern_out),
        .pattern_oe   (pattern_oe),
        .frame_strobe (frame_strobe)
    );

    always #5 sampleClock = ~sampleClock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sampleClock);
        #1;
    endtask

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    function automatic logic [15:0] ref_seed();
        return (seed_m == 16'h0000) ? 16'h0001 : seed_m;
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        check_val("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic configure(input int m, input int dv, input int ln, input logic [15:0] sd);
        mode_m = m; div_m = dv; len_m = ln; seed_m = sd;
        cfg_write(2'd0, 32'(m) | 32'hFFFF_FFFC);
        cfg_write(2'd1, 32'(dv));
        cfg_write(2'd2, 32'(ln));
        cfg_write(2'd3, {16'hDEAD, sd});
    endtask

    task automatic ram_load();
        for (int i = 0; i < 64; i++) begin
            pat_wr   = 1'b1;
            pat_addr = 6'(i);
            pat_data = ram_m[i];
            step();
        end
        pat_wr = 1'b0;
    endtask

    // From IDLE: raise enable, check the single LOAD cycle, land on first RUN cycle
    task automatic enter_run(input string tag);
        enable = 1'b1;
        step();
        check_val({tag, "_load_ready"}, {31'd0, cfg_ready}, 32'd0);
        check_val({tag, "_load_oe"}, {31'd0, pattern_oe}, 32'd0);
        check_val({tag, "_load_strobe"}, {31'd0, frame_strobe}, 32'd0);
        step();
    endtask

    // RUN cycle c shows step k = c/(DIV+1); strobe when step k lands on the seed
    task automatic run_check(input string tag, input int n);
        int          k, k_cur;
        logic [15:0] lfsr_v, exp_p;
        logic        frame, exp_s;
        k_cur  = 0;
        lfsr_v = ref_seed();
        for (int c = 0; c < n; c++) begin
            k = c / (div_m + 1);
            if (k != k_cur) begin
                lfsr_v = ref_lfsr(lfsr_v);
                k_cur  = k;
            end
            if (mode_m == 0) begin
                exp_p = k[15:0];
                frame = (k % 65536) == 0;
            end else if (mode_m == 1) begin
                exp_p = 16'h0001 << (k % 16);
                frame = (k % 16) == 0;
            end else if (mode_m == 2) begin
                exp_p = lfsr_v;
                frame = (lfsr_v == ref_seed());
            end else begin
                exp_p = ram_m[k % (len_m + 1)];
                frame = (k % (len_m + 1)) == 0;
            end
            exp_s = (c > 0) && ((c % (div_m + 1)) == 0) && frame;
            check_val({tag, "_pattern"}, {16'd0, pattern_out}, {16'd0, exp_p});
            check_val({tag, "_strobe"}, {31'd0, frame_strobe}, {31'd0, exp_s});
            check_val({tag, "_oe"}, {31'd0, pattern_oe}, 32'd1);
            check_val({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
            last_pat_m = exp_p;
            if (c < n - 1) begin
                step();
            end
        end
    endtask

    task automatic go_idle(input string tag);
        enable = 1'b0;
        step();
        check_val({tag, "_idle_oe"}, {31'd0, pattern_oe}, 32'd0);
        check_val({tag, "_idle_hold"}, {16'd0, pattern_out}, {16'd0, last_pat_m});
        check_val({tag, "_idle_ready"}, {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        extReset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0;
        cfg_data = 32'd0; pat_wr = 1'b0; pat_addr = 6'd0; pat_data = 16'd0;
        for (int i = 0; i < 64; i++) ram_m[i] = 16'(($urandom));
        #22;
        check_val("rst_pattern", {16'd0, pattern_out}, 32'd0);
        check_val("rst_oe", {31'd0, pattern_oe}, 32'd0);
        check_val("rst_strobe", {31'd0, frame_strobe}, 32'd0);
        check_val("rst_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge sampleClock);
        extReset = 1'b0;
        step();

        // Reset configuration: counter, DIV=0; run across the FFFF->0000 wrap
        mode_m = 0; div_m = 0; len_m = 63; seed_m = 16'h0001;
        enter_run("cnt");
        run_check("cnt", 65540);
        go_idle("cnt");

        // Walking one, DIV=3, two full rotations
        configure(1, 3, 63, 16'h0001);
        enter_run("walk");
        run_check("walk", 140);

        // Enable drop together with a DIV write: IDLE, write kept, no LOAD
        enable = 1'b0; cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 32'd2;
        step();
        cfg_valid = 1'b0;
        check_val("drop_oe", {31'd0, pattern_oe}, 32'd0);
        check_val("drop_ready", {31'd0, cfg_ready}, 32'd1);
        check_val("drop_hold", {16'd0, pattern_out}, {16'd0, last_pat_m});
        step();
        check_val("drop_no_load", {31'd0, cfg_ready}, 32'd1);
        div_m = 2;
        enter_run("walk2");
        run_check("walk2", 40);
        go_idle("walk2");

        // LFSR with SEED=0 (substituted by 0001)
        configure(2, $urandom_range(0, 2), 63, 16'h0000);
        enter_run("lfsr");
        run_check("lfsr", 150);
        go_idle("lfsr");

        // MODE write mid-RUN restarts from SEED
        configure(0, 1, 63, 16'h1234);
        enter_run("pre_rst");
        run_check("pre_rst", 21);
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 32'd2;
        step();
        cfg_valid = 1'b0;
        check_val("restart_ready", {31'd0, cfg_ready}, 32'd0);
        check_val("restart_oe", {31'd0, pattern_oe}, 32'd0);
        step();
        mode_m = 2;
        run_check("restart", 40);
        go_idle("restart");

        // Playback LEN=3, DIV=0
        ram_m[0] = 16'hA5A5; ram_m[1] = 16'h5A5A; ram_m[2] = 16'hFFFF; ram_m[3] = 16'h0000;
        ram_load();
        configure(3, 0, 3, 16'h0001);
        enter_run("play");
        run_check("play", 20);

        // Random configurations
        for (int t = 0; t < 12; t++) begin
            int m;
            go_idle("rnd");
            m = $urandom_range(0, 3);
            if (m == 3) begin
                for (int i = 0; i < 64; i++) ram_m[i] = 16'($urandom);
                ram_load();
            end
            configure(m, $urandom_range(0, 3), $urandom_range(0, 7),
                      ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            enter_run("rnd");
            run_check("rnd", $urandom_range(20, 120));
        end

        // Asynchronous reset while in RUN
        #2;
        extReset = 1'b1;
        #1;
        check_val("arst_pattern", {16'd0, pattern_out}, 32'd0);
        check_val("arst_oe", {31'd0, pattern_oe}, 32'd0);
        check_val("arst_strobe", {31'd0, frame_strobe}, 32'd0);
        check_val("arst_ready", {31'd0, cfg_ready}, 32'd1);
        enable = 1'b0;
        @(negedge sampleClock);
        extReset = 1'b0;
        step();
        mode_m = 0; div_m = 0; len_m = 63; seed_m = 16'h0001;
        enter_run("post_rst");
        run_check("post_rst", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
